// File: rtl/round_robin_arbiter_if.sv
// Request/grant bundle between N bus masters and the round-robin arbiter.
// The master side drives requests, and the arbiter (slave side) returns a registered one-hot grant.
interface round_robin_arbiter_if #(
  parameter int INPUTS      = 4,
  parameter int INDEX_WIDTH = (INPUTS > 1) ? $clog2(INPUTS) : 1
);
  logic [INPUTS-1:0]      request;
  logic [INPUTS-1:0]      grant;
  logic                   grantValid;
  logic [INDEX_WIDTH-1:0] grantIndex;

  modport master (output request, input grant, grantValid, grantIndex);
  modport slave  (input request, output grant, grantValid, grantIndex);
endinterface

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter: a registered one-hot grant appears one edge after the request is sampled.
// The owner keeps the grant while its request stays high; on release it hands off to the next requester with no bubble.
module round_robin_arbiter #(
  parameter int INPUTS = 4,
  localparam int INDEX_WIDTH = (INPUTS > 1) ? $clog2(INPUTS) : 1
) (
  input logic                  clk,
  input logic                  rst,
  round_robin_arbiter_if.slave bus
);

  typedef enum logic {
    S_IDLE,
    S_GRANTED
  } state_t;

  state_t                 r_state;
  logic [INPUTS-1:0]      r_grant;
  logic                   r_grant_valid;
  logic [INDEX_WIDTH-1:0] r_grant_index;
  logic [INDEX_WIDTH-1:0] r_last_grant;

  logic                   w_found;
  logic [INDEX_WIDTH-1:0] w_next_idx;
  logic [INPUTS-1:0]      w_next_grant;

  // Scan starts just after the last owner, so a releasing owner is always scanned last.
  always_comb begin
    w_found      = 1'b0;
    w_next_idx   = '0;
    w_next_grant = '0;
    for (int k = 1; k <= INPUTS; k++) begin
      if (!w_found && bus.request[(int'(r_last_grant) + k) % INPUTS]) begin
        w_found    = 1'b1;
        w_next_idx = INDEX_WIDTH'((int'(r_last_grant) + k) % INPUTS);
      end
    end
    if (w_found) begin
      w_next_grant[w_next_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_grant       <= '0;
      r_grant_valid <= 1'b0;
      r_grant_index <= '0;
      r_last_grant  <= INDEX_WIDTH'(INPUTS - 1);
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state       <= S_GRANTED;
            r_grant       <= w_next_grant;
            r_grant_valid <= 1'b1;
            r_grant_index <= w_next_idx;
            r_last_grant  <= w_next_idx;
          end
        end
        S_GRANTED: begin
          if (!bus.request[r_grant_index]) begin
            if (w_found) begin
              r_grant       <= w_next_grant;
              r_grant_index <= w_next_idx;
              r_last_grant  <= w_next_idx;
            end else begin
              r_state       <= S_IDLE;
              r_grant       <= '0;
              r_grant_valid <= 1'b0;
              r_grant_index <= '0;
            end
          end
        end
        default: begin
          r_state       <= S_IDLE;
          r_grant       <= '0;
          r_grant_valid <= 1'b0;
          r_grant_index <= '0;
        end
      endcase
    end
  end

  assign bus.grant      = r_grant;
  assign bus.grantValid = r_grant_valid;
  assign bus.grantIndex = r_grant_index;

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Bench for round_robin_arbiter: directed scenarios on a 4-input build, plus random stress
// on 4-, 1- and 8-input builds against a queue-free round-robin reference model.
module tb_round_robin_arbiter;

  logic clk;
  logic rst;

  round_robin_arbiter_if #(.INPUTS(4)) if4 ();
  round_robin_arbiter_if #(.INPUTS(1)) if1 ();
  round_robin_arbiter_if #(.INPUTS(8)) if8 ();

  round_robin_arbiter #(.INPUTS(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
  round_robin_arbiter #(.INPUTS(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  round_robin_arbiter #(.INPUTS(8)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  int         nk[3] = '{4, 1, 8};
  int         m_owner[3];
  int         m_last[3];
  int         wt[3][8];
  logic [7:0] rq[3];
  logic [7:0] prev_g[3];
  logic [7:0] g_obs[3];
  logic       v_obs[3];
  int         idx_obs[3];

  always_comb begin
    g_obs[0]   = {4'b0, if4.grant};
    g_obs[1]   = {7'b0, if1.grant};
    g_obs[2]   = if8.grant;
    v_obs[0]   = if4.grantValid;
    v_obs[1]   = if1.grantValid;
    v_obs[2]   = if8.grantValid;
    idx_obs[0] = int'(if4.grantIndex);
    idx_obs[1] = int'(if1.grantIndex);
    idx_obs[2] = int'(if8.grantIndex);
  end

  // Owner keeps the bus while requesting; otherwise the first requester after the last owner wins.
  function automatic int rr_pick(int n, int owner, int last, logic [7:0] req);
    if (owner >= 0 && req[owner]) return owner;
    for (int j = 1; j <= n; j++) begin
      if (req[(last + j) % n]) return (last + j) % n;
    end
    return -1;
  endfunction

  task automatic cycle();
    int nw;
    rq[0] = {4'b0, if4.request};
    rq[1] = {7'b0, if1.request};
    rq[2] = if8.request;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_owner[k] = -1;
        m_last[k]  = nk[k] - 1;
      end else begin
        nw         = rr_pick(nk[k], m_owner[k], m_last[k], rq[k]);
        m_owner[k] = nw;
        if (nw >= 0) m_last[k] = nw;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if4.request = 4'b1111;
    for (int c = 0; c < 2; c++) begin
      cycle();
      n_chk++;
      if (if4.grant !== 4'b0000) begin
        n_err++;
        $display("FAIL reset_grant cyc%0d: got %b expected 0000", c, if4.grant);
      end
      n_chk++;
      if (if4.grantValid !== 1'b0) begin
        n_err++;
        $display("FAIL reset_valid cyc%0d: got %b expected 0", c, if4.grantValid);
      end
      n_chk++;
      if (if4.grantIndex !== 2'd0) begin
        n_err++;
        $display("FAIL reset_index cyc%0d: got %0d expected 0", c, if4.grantIndex);
      end
    end
    rst = 1'b0;
    cycle();
    n_chk++;
    if (if4.grant !== 4'b0001) begin
      n_err++;
      $display("FAIL reset_release: got %b expected 0001", if4.grant);
    end
  endtask

  task automatic test_single_master();
    if4.request = 4'b0000;
    cycle();
    n_chk++;
    if (if4.grant !== 4'b0000 || if4.grantValid !== 1'b0) begin
      n_err++;
      $display("FAIL single_idle: got grant=%b valid=%b expected 0000/0", if4.grant, if4.grantValid);
    end
    if4.request = 4'b0100;
    cycle();
    n_chk++;
    if (if4.grant !== 4'b0100 || if4.grantIndex !== 2'd2 || if4.grantValid !== 1'b1) begin
      n_err++;
      $display("FAIL single_grant: got grant=%b idx=%0d valid=%b expected 0100/2/1",
               if4.grant, if4.grantIndex, if4.grantValid);
    end
    for (int c = 0; c < 10; c++) begin
      cycle();
      n_chk++;
      if (if4.grant !== 4'b0100) begin
        n_err++;
        $display("FAIL single_hold cyc%0d: got %b expected 0100", c, if4.grant);
      end
    end
    if4.request = 4'b0000;
    cycle();
    n_chk++;
    if (if4.grant !== 4'b0000 || if4.grantIndex !== 2'd0 || if4.grantValid !== 1'b0) begin
      n_err++;
      $display("FAIL single_release: got grant=%b idx=%0d valid=%b expected 0000/0/0",
               if4.grant, if4.grantIndex, if4.grantValid);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] cur;
    logic [3:0] exp_seq [4];
    exp_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rst = 1'b1;
    if4.request = 4'b1111;
    cycle();
    rst = 1'b0;
    cycle();
    cur = 4'b0001;
    n_chk++;
    if (if4.grant !== cur) begin
      n_err++;
      $display("FAIL rotate_first: got %b expected %b", if4.grant, cur);
    end
    for (int i = 0; i < 4; i++) begin
      if4.request = 4'b1111 & ~cur;
      cycle();
      n_chk++;
      if (if4.grant !== exp_seq[i]) begin
        n_err++;
        $display("FAIL rotate_step%0d: got %b expected %b", i, if4.grant, exp_seq[i]);
      end
      cur = exp_seq[i];
      if4.request = 4'b1111;
      cycle();
      n_chk++;
      if (if4.grant !== cur) begin
        n_err++;
        $display("FAIL rotate_hold%0d: got %b expected %b", i, if4.grant, cur);
      end
    end
  endtask

  task automatic test_skip_wrap();
    rst = 1'b1;
    if4.request = 4'b1000;
    cycle();
    rst = 1'b0;
    cycle();
    n_chk++;
    if (if4.grant !== 4'b1000 || if4.grantIndex !== 2'd3) begin
      n_err++;
      $display("FAIL wrap_owner3: got %b idx=%0d expected 1000/3", if4.grant, if4.grantIndex);
    end
    if4.request = 4'b0011;
    cycle();
    n_chk++;
    if (if4.grant !== 4'b0001 || if4.grantIndex !== 2'd0) begin
      n_err++;
      $display("FAIL wrap_to0: got %b idx=%0d expected 0001/0", if4.grant, if4.grantIndex);
    end
    if4.request = 4'b0010;
    cycle();
    n_chk++;
    if (if4.grant !== 4'b0010 || if4.grantIndex !== 2'd1) begin
      n_err++;
      $display("FAIL wrap_to1: got %b idx=%0d expected 0010/1", if4.grant, if4.grantIndex);
    end
    if4.request = 4'b0000;
    cycle();
  endtask

  task automatic test_reset_mid_grant();
    rst = 1'b1;
    if4.request = 4'b0100;
    cycle();
    rst = 1'b0;
    cycle();
    cycle();
    n_chk++;
    if (if4.grant !== 4'b0100) begin
      n_err++;
      $display("FAIL midrst_held: got %b expected 0100", if4.grant);
    end
    rst = 1'b1;
    if4.request = 4'b1111;
    cycle();
    n_chk++;
    if (if4.grant !== 4'b0000 || if4.grantValid !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_clear: got %b valid=%b expected 0000/0", if4.grant, if4.grantValid);
    end
    rst = 1'b0;
    cycle();
    n_chk++;
    if (if4.grant !== 4'b0001) begin
      n_err++;
      $display("FAIL midrst_pointer: got %b expected 0001", if4.grant);
    end
    if4.request = 4'b0000;
    cycle();
  endtask

  task automatic test_one_input();
    if1.request = 1'b1;
    cycle();
    n_chk++;
    if (if1.grant !== 1'b1 || if1.grantValid !== 1'b1 || if1.grantIndex !== 1'b0) begin
      n_err++;
      $display("FAIL one_grant: got %b valid=%b idx=%0d expected 1/1/0",
               if1.grant, if1.grantValid, if1.grantIndex);
    end
    if1.request = 1'b0;
    cycle();
    n_chk++;
    if (if1.grant !== 1'b0 || if1.grantValid !== 1'b0) begin
      n_err++;
      $display("FAIL one_release: got %b valid=%b expected 0/0", if1.grant, if1.grantValid);
    end
  endtask

  task automatic test_random_stress();
    logic [7:0] exp_g;
    int         exp_i;
    int         worst;
    logic       new_grant;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      prev_g[k] = 8'h00;
      for (int i = 0; i < 8; i++) wt[k][i] = 0;
    end
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 4; i++) if ($urandom_range(3) == 0) if4.request[i] = ~if4.request[i];
      for (int i = 0; i < 8; i++) if ($urandom_range(3) == 0) if8.request[i] = ~if8.request[i];
      if ($urandom_range(2) == 0) if1.request = ~if1.request;
      cycle();
      for (int k = 0; k < 3; k++) begin
        exp_g = (m_owner[k] < 0) ? 8'h00 : (8'h01 << m_owner[k]);
        exp_i = (m_owner[k] < 0) ? 0 : m_owner[k];
        n_chk++;
        if (g_obs[k] !== exp_g) begin
          n_err++;
          $display("FAIL stress_grant n=%0d cyc%0d: got %b expected %b", nk[k], c, g_obs[k], exp_g);
        end
        n_chk++;
        if (idx_obs[k] != exp_i) begin
          n_err++;
          $display("FAIL stress_index n=%0d cyc%0d: got %0d expected %0d", nk[k], c, idx_obs[k], exp_i);
        end
        n_chk++;
        if ($countones(g_obs[k]) > 1 || v_obs[k] !== (|g_obs[k]) ||
            (g_obs[k] != 8'h00 && g_obs[k][idx_obs[k]] !== 1'b1)) begin
          n_err++;
          $display("FAIL stress_invariant n=%0d cyc%0d: grant=%b valid=%b idx=%0d",
                   nk[k], c, g_obs[k], v_obs[k], idx_obs[k]);
        end
        new_grant = (g_obs[k] != prev_g[k]) && (g_obs[k] != 8'h00);
        worst = 0;
        for (int i = 0; i < nk[k]; i++) begin
          if (rq[k][i] && !g_obs[k][i]) begin
            if (new_grant) wt[k][i]++;
          end else begin
            wt[k][i] = 0;
          end
          if (wt[k][i] > worst) worst = wt[k][i];
        end
        n_chk++;
        if (worst > nk[k] - 1) begin
          n_err++;
          $display("FAIL stress_starve n=%0d cyc%0d: waited %0d grants, limit %0d", nk[k], c, worst, nk[k] - 1);
        end
        prev_g[k] = g_obs[k];
      end
    end
  endtask

  initial begin
    rst         = 1'b1;
    if4.request = '0;
    if1.request = '0;
    if8.request = '0;
    for (int k = 0; k < 3; k++) begin
      m_owner[k] = -1;
      m_last[k]  = nk[k] - 1;
    end
    test_reset();
    test_single_master();
    test_rotation();
    test_skip_wrap();
    test_reset_mid_grant();
    test_one_input();
    test_random_stress();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
